prefetch_queue: RTL and testbench

Holds instruction-stream words prefetched from memory and hands them to the instruction decoder and to the scheduler. Assembles each 16-bit word from serial RX beats of NSHIFT bits. Queues up to DEPTH words. Serves the scheduler's imm16 requests through a circular shift register that streams NSHIFT bits per cycle. Sits between the RX interface/PC prefetch logic upstream and the decoder and scheduler downstream.

---
 rtl/prefetch_queue.sv | 165 ++++++++++++++++
 tb/tb_prefetch_queue.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
// prefetch_queue: assembles 16-bit instruction-stream words from serial RX
// beats and queues them for the decoder. It also serves the scheduler's
// imm16 requests through a rotating shift register.
// Optional feature macro: PREFETCH_FORWARD_EN. When it is defined, a word
// that completes into an empty queue while an imm16 request is waiting is
// written straight into the imm register and skips the queue.
module prefetch_queue #(
  parameter int REG_BITS = 8,
  parameter int NSHIFT   = 2,
  parameter int DEPTH    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_data_valid,
  input  logic [NSHIFT-1:0]       rx_pins,
  input  logic                    read_in_flight,
  input  logic                    flush,
  output logic                    can_prefetch,
  output logic                    any_prefetched,
  output logic                    overflow,
  output logic [2*REG_BITS-1:0]   inst_word,
  output logic                    inst_word_valid,
  input  logic                    inst_word_take,
  input  logic                    load_imm16,
  output logic                    imm16_loaded,
  input  logic                    next_imm_data,
  output logic [NSHIFT-1:0]       imm_data_in,
  output logic [2*REG_BITS-1:0]   imm_full
);

  localparam int WORD  = 2 * REG_BITS;
  localparam int BEATS = WORD / NSHIFT;
  localparam int BW    = $clog2(BEATS);
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic [WORD-1:0]        queue_mem [DEPTH];
  logic [PW-1:0]          head;
  logic [PW-1:0]          tail;
  logic [CW-1:0]          count;
  logic [BW-1:0]          beat_cnt;
  logic [WORD-NSHIFT-1:0] asm_reg;
  logic                   discard;
  logic [WORD-1:0]        imm_reg;

  logic                   word_done;
  logic [WORD-1:0]        done_word;
  logic                   queue_empty;
  logic                   queue_full;
  logic                   take_pop;
  logic                   imm_pop;
  logic                   fwd;
  logic                   do_pop;
  logic                   push_req;
  logic                   do_push;
  logic                   drop_ovf;

  // Circular pointer advance, wrapping at DEPTH even when it is not a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Decode this cycle's push, pop and forward decisions. Flush overrides all of them.
  // Beats are shifted in from the top of asm_reg, so earlier beats end up in
  // the low bits. The final beat arrives directly on rx_pins and becomes the top slice.
  always_comb begin
    word_done   = rx_data_valid && (beat_cnt == BW'(BEATS - 1));
    done_word   = {rx_pins, asm_reg};
    queue_empty = (count == '0);
    queue_full  = (count == CW'(DEPTH));
    take_pop    = inst_word_take && !queue_empty;
    imm_pop     = load_imm16 && !imm16_loaded && !inst_word_take && !queue_empty;
`ifdef PREFETCH_FORWARD_EN
    fwd         = word_done && queue_empty && load_imm16 && !imm16_loaded && !discard && !flush;
`else
    fwd         = 1'b0;
`endif
    do_pop      = !flush && (take_pop || imm_pop);
    push_req    = !flush && word_done && !discard && !fwd;
    do_push     = push_req && (!queue_full || do_pop);
    drop_ovf    = push_req && queue_full && !do_pop;
  end

  // Downstream-facing outputs. These are combinational views of the state plus read_in_flight.
  always_comb begin
    inst_word       = queue_mem[head];
    inst_word_valid = !queue_empty;
    can_prefetch    = (32'(count) + 32'(read_in_flight)) < 32'(DEPTH);
    any_prefetched  = !queue_empty || (beat_cnt != '0);
    imm_data_in     = imm_reg[NSHIFT-1:0];
    imm_full        = imm_reg;
  end

  // Beat counter and assembly shift register. Flush deliberately leaves
  // these untouched, so an in-flight word still lines up correctly.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt <= '0;
      asm_reg  <= '0;
    end else if (rx_data_valid) begin
      beat_cnt <= word_done ? '0 : beat_cnt + 1'b1;
      asm_reg  <= {rx_pins, asm_reg[WORD-NSHIFT-1:NSHIFT]};
    end
  end

  // The discard flag swallows the one word that was already under way when the PC changed.
  always_ff @(posedge clk) begin
    if (reset) begin
      discard <= 1'b0;
    end else if (flush) begin
      discard <= (beat_cnt != '0) || read_in_flight;
    end else if (word_done) begin
      discard <= 1'b0;
    end
  end

  // Queue bookkeeping. A simultaneous push and pop keeps the count unchanged, even when the queue is full.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_pop)  head <= ptr_inc(head);
      if (do_push) tail <= ptr_inc(tail);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Word storage. Slots need no reset because count gates validity.
  always_ff @(posedge clk) begin
    if (do_push) queue_mem[tail] <= done_word;
  end

  // Sticky overflow: a word was lost because the queue had no room for it.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop_ovf) begin
      overflow <= 1'b1;
    end
  end

  // imm register: a load (from the queue head or forwarded) beats rotation. Flush leaves the register alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      imm_reg      <= '0;
      imm16_loaded <= 1'b0;
    end else begin
      imm16_loaded <= (imm_pop && !flush) || fwd;
      if (imm_pop && !flush) begin
        imm_reg <= queue_mem[head];
      end else if (fwd) begin
        imm_reg <= done_word;
      end else if (next_imm_data) begin
        imm_reg <= {imm_reg[NSHIFT-1:0], imm_reg[WORD-1:NSHIFT]};
      end
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// tb_prefetch_queue: directed scenarios plus a randomized run. The random
// run is checked against a word-level reference model built on a queue.
// Honors PREFETCH_FORWARD_EN in the same way as the design.
module tb_prefetch_queue;

  localparam int REG_BITS = 8;
  localparam int NSHIFT   = 2;
  localparam int DEPTH    = 2;
  localparam int WORD     = 2 * REG_BITS;
  localparam int BEATS    = WORD / NSHIFT;

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_data_valid;
  logic [NSHIFT-1:0] rx_pins;
  logic              read_in_flight;
  logic              flush;
  logic              can_prefetch;
  logic              any_prefetched;
  logic              overflow;
  logic [WORD-1:0]   inst_word;
  logic              inst_word_valid;
  logic              inst_word_take;
  logic              load_imm16;
  logic              imm16_loaded;
  logic              next_imm_data;
  logic [NSHIFT-1:0] imm_data_in;
  logic [WORD-1:0]   imm_full;

  int errors = 0;
  int checks = 0;

  // Reference model state, kept at the word level.
  logic [WORD-1:0] m_q[$];
  int              m_beats;
  logic [WORD-1:0] m_partial;
  bit              m_discard;
  bit              m_overflow;
  logic [WORD-1:0] m_imm;
  bit              m_loaded;

  prefetch_queue #(.REG_BITS(REG_BITS), .NSHIFT(NSHIFT), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rx_data_valid(rx_data_valid), .rx_pins(rx_pins),
    .read_in_flight(read_in_flight), .flush(flush), .can_prefetch(can_prefetch),
    .any_prefetched(any_prefetched), .overflow(overflow), .inst_word(inst_word),
    .inst_word_valid(inst_word_valid), .inst_word_take(inst_word_take),
    .load_imm16(load_imm16), .imm16_loaded(imm16_loaded), .next_imm_data(next_imm_data),
    .imm_data_in(imm_data_in), .imm_full(imm_full)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q.delete();
    m_beats    = 0;
    m_partial  = '0;
    m_discard  = 0;
    m_overflow = 0;
    m_imm      = '0;
    m_loaded   = 0;
  endtask

  // Advance the model by one clock using the inputs that were held across the edge.
  task automatic model_step();
    logic [WORD-1:0] word;
    logic [WORD-1:0] head_word;
    bit complete, take_pop, imm_pop, fwd;
    int sz;
    sz        = m_q.size();
    head_word = (sz != 0) ? m_q[0] : '0;
    complete  = rx_data_valid && (m_beats == BEATS - 1);
    word      = m_partial;
    word[m_beats*NSHIFT +: NSHIFT] = rx_pins;
    take_pop  = inst_word_take && sz != 0;
    imm_pop   = load_imm16 && !m_loaded && !inst_word_take && sz != 0;
    fwd       = 0;
`ifdef PREFETCH_FORWARD_EN
    fwd       = complete && sz == 0 && load_imm16 && !m_loaded && !m_discard && !flush;
`endif
    if (!flush && imm_pop) m_imm = head_word;
    else if (fwd) m_imm = word;
    else if (next_imm_data) m_imm = (m_imm >> NSHIFT) | (m_imm << (WORD - NSHIFT));
    m_loaded = (!flush && imm_pop) || fwd;
    if (flush) begin
      m_q.delete();
    end else begin
      if (take_pop || imm_pop) void'(m_q.pop_front());
      if (complete && !m_discard && !fwd) begin
        if (m_q.size() < DEPTH) m_q.push_back(word);
        else m_overflow = 1;
      end
    end
    if (flush) m_discard = (m_beats != 0) || read_in_flight;
    else if (complete) m_discard = 0;
    if (rx_data_valid) begin
      m_partial = word;
      m_beats   = complete ? 0 : m_beats + 1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else model_step();
  endtask

  task automatic idle_inputs();
    rx_data_valid  = 0;
    rx_pins        = '0;
    read_in_flight = 0;
    flush          = 0;
    inst_word_take = 0;
    load_imm16     = 0;
    next_imm_data  = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    cycle();
    cycle();
    reset = 0;
  endtask

  task automatic send_beat(input logic [NSHIFT-1:0] p);
    rx_data_valid = 1;
    rx_pins       = p;
    cycle();
    rx_data_valid = 0;
  endtask

  task automatic send_word(input logic [WORD-1:0] w);
    for (int k = 0; k < BEATS; k++) send_beat(w[k*NSHIFT +: NSHIFT]);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (can_prefetch !== 1'b1) begin errors++; $display("[TB] FAIL reset_can_prefetch: got %b want 1", can_prefetch); end
    checks++; if (any_prefetched !== 1'b0) begin errors++; $display("[TB] FAIL reset_any_prefetched: got %b want 0", any_prefetched); end
    checks++; if (inst_word_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", inst_word_valid); end
    checks++; if (imm_full !== 16'h0000) begin errors++; $display("[TB] FAIL reset_imm_full: got %h want 0000", imm_full); end
    checks++; if (imm16_loaded !== 1'b0) begin errors++; $display("[TB] FAIL reset_imm16_loaded: got %b want 0", imm16_loaded); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_word_assembly();
    logic [WORD-1:0] w;
    do_reset();
    w = 16'h1234;
    for (int k = 0; k < BEATS; k++) begin
      send_beat(w[k*NSHIFT +: NSHIFT]);
      if (k == 0) begin
        checks++; if (any_prefetched !== 1'b1) begin errors++; $display("[TB] FAIL asm_any_first_beat: got %b want 1", any_prefetched); end
      end
      if (k == BEATS - 2) begin
        checks++; if (inst_word_valid !== 1'b0) begin errors++; $display("[TB] FAIL asm_valid_early: got %b want 0", inst_word_valid); end
      end
    end
    checks++; if (inst_word_valid !== 1'b1) begin errors++; $display("[TB] FAIL asm_valid: got %b want 1", inst_word_valid); end
    checks++; if (inst_word !== 16'h1234) begin errors++; $display("[TB] FAIL asm_word: got %h want 1234", inst_word); end
  endtask

  task automatic test_imm_load();
    int pulses;
    do_reset();
    send_word(16'hAAAA);
    send_word(16'h5555);
    checks++; if (can_prefetch !== 1'b0) begin errors++; $display("[TB] FAIL imm_full_queue_can_prefetch: got %b want 0", can_prefetch); end
    pulses = 0;
    load_imm16 = 1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (imm16_loaded === 1'b1) begin
        pulses++;
        load_imm16 = 0;
      end
    end
    load_imm16 = 0;
    checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL imm_pulse_count: got %0d want 1", pulses); end
    checks++; if (imm_full !== 16'hAAAA) begin errors++; $display("[TB] FAIL imm_value: got %h want aaaa", imm_full); end
    checks++; if (inst_word !== 16'h5555) begin errors++; $display("[TB] FAIL imm_remaining_head: got %h want 5555", inst_word); end
    checks++; if (can_prefetch !== 1'b1) begin errors++; $display("[TB] FAIL imm_count_one: can_prefetch got %b want 1", can_prefetch); end
    inst_word_take = 1;
    cycle();
    inst_word_take = 0;
    checks++; if (inst_word_valid !== 1'b0) begin errors++; $display("[TB] FAIL imm_take_last: got %b want 0", inst_word_valid); end
  endtask

  task automatic test_rotation();
    logic [WORD-1:0] v;
    logic [NSHIFT-1:0] exp_bits;
    do_reset();
    v = 16'h1234;
    send_word(v);
    load_imm16 = 1;
    cycle();
    load_imm16 = 0;
    checks++; if (imm16_loaded !== 1'b1) begin errors++; $display("[TB] FAIL rot_loaded: got %b want 1", imm16_loaded); end
    checks++; if (imm_full !== v) begin errors++; $display("[TB] FAIL rot_initial: got %h want %h", imm_full, v); end
    for (int k = 0; k < BEATS; k++) begin
      exp_bits = NSHIFT'(v >> (k * NSHIFT));
      checks++; if (imm_data_in !== exp_bits) begin errors++; $display("[TB] FAIL rot_step%0d: got %0d want %0d", k, imm_data_in, exp_bits); end
      next_imm_data = 1;
      cycle();
      next_imm_data = 0;
    end
    checks++; if (imm_full !== v) begin errors++; $display("[TB] FAIL rot_restore: got %h want %h", imm_full, v); end
  endtask

  task automatic test_flush();
    do_reset();
    send_word(16'h4321);
    for (int k = 0; k < 3; k++) send_beat(2'b11);
    flush = 1;
    cycle();
    flush = 0;
    checks++; if (inst_word_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid: got %b want 0", inst_word_valid); end
    for (int k = 0; k < BEATS - 3; k++) send_beat(2'b10);
    checks++; if (inst_word_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_discarded_push: got %b want 0", inst_word_valid); end
    checks++; if (any_prefetched !== 1'b0) begin errors++; $display("[TB] FAIL flush_any: got %b want 0", any_prefetched); end
    send_word(16'h00FF);
    checks++; if (inst_word_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_next_valid: got %b want 1", inst_word_valid); end
    checks++; if (inst_word !== 16'h00FF) begin errors++; $display("[TB] FAIL flush_next_word: got %h want 00ff", inst_word); end
  endtask

  task automatic test_overflow();
    logic [WORD-1:0] w;
    do_reset();
    send_word(16'h1111);
    send_word(16'h2222);
    w = 16'h3333;
    for (int k = 0; k < BEATS - 1; k++) send_beat(w[k*NSHIFT +: NSHIFT]);
    rx_data_valid  = 1;
    rx_pins        = w[WORD-1 -: NSHIFT];
    inst_word_take = 1;
    cycle();
    rx_data_valid  = 0;
    inst_word_take = 0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_push_pop: got %b want 0", overflow); end
    checks++; if (inst_word !== 16'h2222) begin errors++; $display("[TB] FAIL ovf_head_after_pop: got %h want 2222", inst_word); end
    checks++; if (can_prefetch !== 1'b0) begin errors++; $display("[TB] FAIL ovf_still_full: got %b want 0", can_prefetch); end
    send_word(16'h4444);
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b want 1", overflow); end
    inst_word_take = 1;
    cycle();
    inst_word_take = 0;
    checks++; if (inst_word !== 16'h3333) begin errors++; $display("[TB] FAIL ovf_second_word: got %h want 3333", inst_word); end
    for (int i = 0; i < 5; i++) cycle();
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b want 1", overflow); end
    do_reset();
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_cleared: got %b want 0", overflow); end
  endtask

  task automatic test_forward();
    do_reset();
    load_imm16 = 1;
    send_word(16'hBEEF);
`ifdef PREFETCH_FORWARD_EN
    checks++; if (imm16_loaded !== 1'b1) begin errors++; $display("[TB] FAIL fwd_loaded_early: got %b want 1", imm16_loaded); end
    load_imm16 = 0;
`else
    checks++; if (imm16_loaded !== 1'b0) begin errors++; $display("[TB] FAIL fwd_loaded_early: got %b want 0", imm16_loaded); end
    cycle();
    load_imm16 = 0;
    checks++; if (imm16_loaded !== 1'b1) begin errors++; $display("[TB] FAIL fwd_loaded_late: got %b want 1", imm16_loaded); end
`endif
    checks++; if (inst_word_valid !== 1'b0) begin errors++; $display("[TB] FAIL fwd_valid: got %b want 0", inst_word_valid); end
    checks++; if (imm_full !== 16'hBEEF) begin errors++; $display("[TB] FAIL fwd_imm: got %h want beef", imm_full); end
    cycle();
    checks++; if (imm16_loaded !== 1'b0) begin errors++; $display("[TB] FAIL fwd_pulse_end: got %b want 0", imm16_loaded); end
  endtask

  task automatic test_random();
    bit exp_can;
    bit exp_any;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rx_data_valid  = ($urandom % 4) != 0;
      rx_pins        = NSHIFT'($urandom);
      read_in_flight = ($urandom % 4) == 0;
      flush          = ($urandom % 40) == 0;
      inst_word_take = ($urandom % 3) == 0;
      load_imm16     = ($urandom % 4) == 0;
      next_imm_data  = ($urandom % 3) == 0;
      cycle();
      exp_can = (m_q.size() + int'(read_in_flight)) < DEPTH;
      exp_any = (m_q.size() != 0) || (m_beats != 0);
      checks++; if (inst_word_valid !== (m_q.size() != 0)) begin errors++; $display("[TB] FAIL rnd_valid@%0d: got %b want %b", n, inst_word_valid, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        checks++; if (inst_word !== m_q[0]) begin errors++; $display("[TB] FAIL rnd_word@%0d: got %h want %h", n, inst_word, m_q[0]); end
      end
      checks++; if (can_prefetch !== exp_can) begin errors++; $display("[TB] FAIL rnd_can_prefetch@%0d: got %b want %b", n, can_prefetch, exp_can); end
      checks++; if (any_prefetched !== exp_any) begin errors++; $display("[TB] FAIL rnd_any@%0d: got %b want %b", n, any_prefetched, exp_any); end
      checks++; if (overflow !== m_overflow) begin errors++; $display("[TB] FAIL rnd_overflow@%0d: got %b want %b", n, overflow, m_overflow); end
      checks++; if (imm16_loaded !== m_loaded) begin errors++; $display("[TB] FAIL rnd_loaded@%0d: got %b want %b", n, imm16_loaded, m_loaded); end
      checks++; if (imm_full !== m_imm) begin errors++; $display("[TB] FAIL rnd_imm@%0d: got %h want %h", n, imm_full, m_imm); end
      checks++; if (imm_data_in !== m_imm[NSHIFT-1:0]) begin errors++; $display("[TB] FAIL rnd_imm_bits@%0d: got %0d want %0d", n, imm_data_in, m_imm[NSHIFT-1:0]); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    model_reset();
    test_reset();
    test_word_assembly();
    test_imm_load();
    test_rotation();
    test_flush();
    test_overflow();
    test_forward();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
